// File: rtl/pattern_detect_fsm_if.sv
// Serial detector bus: sample strobe, data and clear in; match flag and saturating count out.
interface pattern_detect_fsm_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             W;
  logic             clr;
  logic             Zout;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  modport master (output en, W, clr, input  Zout, match_count, count_sat);
  modport slave  (input  en, W, clr, output Zout, match_count, count_sat);
endinterface

// File: rtl/pattern_detect_fsm.sv
// Parametrised serial pattern detector with Mealy/Moore output, optional overlap and a
// saturating match counter. PATTERN bit 0 is the newest sample.
module pattern_detect_fsm #(
  parameter int                     PATTERN_LEN = 2,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 'b01,
  parameter bit                     OVERLAP     = 1'b1,
  parameter bit                     MOORE       = 1'b0,
  parameter int                     CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  _rst,
  pattern_detect_fsm_if.slave   bus
);

  generate
    if (PATTERN_LEN < 2 || PATTERN_LEN > 16) begin : g_bad_len
      $error("pattern_detect_fsm: PATTERN_LEN must be in 2..16");
    end
  endgenerate

  localparam int                FILL_W   = $clog2(PATTERN_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_LEN - 1);

  logic [PATTERN_LEN-2:0] r_hist;
  logic [FILL_W-1:0]      r_fill;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_sat;

  logic [PATTERN_LEN-1:0] w_win;
  logic                   w_full;
  logic                   w_hit;
  logic [CNT_W-1:0]       w_cnt_inc;

  // Window is the held history with the current sample appended as the newest bit.
  assign w_win     = {r_hist, bus.W};
  assign w_full    = (r_fill == FILL_MAX);
  assign w_hit     = bus.en & w_full & (w_win == PATTERN);
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (bus.en) begin
      if (w_hit && !OVERLAP) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_win[PATTERN_LEN-2:0];
        if (!w_full) r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

  // clr wins over a coincident hit; an all-ones count holds and marks saturation.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (bus.clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_hit) begin
      if (&r_cnt) begin
        r_sat <= 1'b1;
      end else begin
        r_cnt <= w_cnt_inc;
        if (&w_cnt_inc) r_sat <= 1'b1;
      end
    end
  end

  assign bus.match_count = r_cnt;
  assign bus.count_sat   = r_sat;

  generate
    if (MOORE) begin : g_moore
      logic r_zout;
      always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) r_zout <= 1'b0;
        else       r_zout <= w_hit;
      end
      assign bus.Zout = r_zout;
    end else begin : g_mealy
      assign bus.Zout = w_hit;
    end
  endgenerate

endmodule

// File: tb/tb_pattern_detect_fsm.sv
// Scoreboard bench: stimulus queues the cycle each Zout pulse is due; a negedge monitor pops and compares.
module tb_pattern_detect_fsm;

  logic clk;
  logic rst_n;
  int   cyc    = 0;
  int   n_tot  = 0;
  int   n_pass = 0;
  int   q [5][$];

  // d0: LEN2 01 Mealy; d1: LEN3 101 overlap; d2: LEN3 101 no overlap; d3: LEN2 01 Moore; d4: LEN2 01 CNT_W=2
  localparam bit [4:0] IS_MOORE = 5'b01000;

  pattern_detect_fsm_if #(.CNT_W(8)) b0 ();
  pattern_detect_fsm_if #(.CNT_W(8)) b1 ();
  pattern_detect_fsm_if #(.CNT_W(8)) b2 ();
  pattern_detect_fsm_if #(.CNT_W(8)) b3 ();
  pattern_detect_fsm_if #(.CNT_W(2)) b4 ();

  pattern_detect_fsm #(.PATTERN_LEN(2), .PATTERN(2'b01), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(8))
    u0 (.clk(clk), ._rst(rst_n), .bus(b0));
  pattern_detect_fsm #(.PATTERN_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(8))
    u1 (.clk(clk), ._rst(rst_n), .bus(b1));
  pattern_detect_fsm #(.PATTERN_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0), .MOORE(1'b0), .CNT_W(8))
    u2 (.clk(clk), ._rst(rst_n), .bus(b2));
  pattern_detect_fsm #(.PATTERN_LEN(2), .PATTERN(2'b01), .OVERLAP(1'b1), .MOORE(1'b1), .CNT_W(8))
    u3 (.clk(clk), ._rst(rst_n), .bus(b3));
  pattern_detect_fsm #(.PATTERN_LEN(2), .PATTERN(2'b01), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(2))
    u4 (.clk(clk), ._rst(rst_n), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int zout(input int d);
    case (d)
      0: return int'(b0.Zout);
      1: return int'(b1.Zout);
      2: return int'(b2.Zout);
      3: return int'(b3.Zout);
      default: return int'(b4.Zout);
    endcase
  endfunction

  function automatic int cnt(input int d);
    case (d)
      0: return int'(b0.match_count);
      1: return int'(b1.match_count);
      2: return int'(b2.match_count);
      3: return int'(b3.match_count);
      default: return int'(b4.match_count);
    endcase
  endfunction

  function automatic int sat(input int d);
    case (d)
      0: return int'(b0.count_sat);
      1: return int'(b1.count_sat);
      2: return int'(b2.count_sat);
      3: return int'(b3.count_sat);
      default: return int'(b4.count_sat);
    endcase
  endfunction

  task automatic drive(input int d, input bit e, input bit w, input bit c);
    case (d)
      0: begin b0.en = e; b0.W = w; b0.clr = c; end
      1: begin b1.en = e; b1.W = w; b1.clr = c; end
      2: begin b2.en = e; b2.W = w; b2.clr = c; end
      3: begin b3.en = e; b3.W = w; b3.clr = c; end
      default: begin b4.en = e; b4.W = w; b4.clr = c; end
    endcase
  endtask

  // One cycle of stimulus on DUT d; a Mealy hit is due this cycle, a Moore hit the next.
  task automatic samp(input int d, input bit e, input bit w, input bit c, input bit exp_hit);
    drive(d, e, w, c);
    if (exp_hit) q[d].push_back(IS_MOORE[d] ? cyc + 1 : cyc);
    @(posedge clk);
    #1;
    drive(d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int d = 0; d < 5; d++) begin
      chk($sformatf("%s_zout_d%0d", tag, d), zout(d), 0);
      chk($sformatf("%s_count_d%0d", tag, d), cnt(d), 0);
      chk($sformatf("%s_sat_d%0d", tag, d), sat(d), 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 5; d++) begin
        if (zout(d) != 0) begin
          if (q[d].size() == 0) chk($sformatf("spurious_zout_d%0d", d), cyc, -1);
          else chk($sformatf("zout_cycle_d%0d", d), cyc, q[d].pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int exp_cnt [5] = '{1, 2, 3, 3, 3};
    int exp_sat [5] = '{0, 0, 1, 1, 1};
    rst_n = 1'b0;
    for (int d = 0; d < 5; d++) drive(d, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: 0,1,1,0,1 -> hits on samples 2 and 5
    samp(0, 1, 0, 0, 0); samp(0, 1, 1, 0, 1); samp(0, 1, 1, 0, 0);
    samp(0, 1, 0, 0, 0); samp(0, 1, 1, 0, 1);
    chk("t1_count", cnt(0), 2);

    // T4: W=1 with en=0 is ignored
    samp(0, 1, 0, 0, 0); samp(0, 0, 1, 0, 0); samp(0, 1, 1, 0, 1);
    chk("t4_count", cnt(0), 3);

    // T2: 1,0,1,0,1 overlapping vs flushed
    samp(1, 1, 1, 0, 0); samp(1, 1, 0, 0, 0); samp(1, 1, 1, 0, 1);
    samp(1, 1, 0, 0, 0); samp(1, 1, 1, 0, 1);
    chk("t2_overlap_count", cnt(1), 2);
    samp(2, 1, 1, 0, 0); samp(2, 1, 0, 0, 0); samp(2, 1, 1, 0, 1);
    samp(2, 1, 0, 0, 0); samp(2, 1, 1, 0, 0);
    chk("t2_nooverlap_count", cnt(2), 1);

    // T3: Moore pulse one cycle after the completing sample
    samp(3, 1, 0, 0, 0); samp(3, 1, 1, 0, 1);
    samp(3, 0, 0, 0, 0); samp(3, 0, 0, 0, 0);
    chk("t3_count", cnt(3), 1);
    chk("t3_zout_idle", zout(3), 0);

    // T5: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      samp(4, 1, 0, 0, 0); samp(4, 1, 1, 0, 1);
      chk($sformatf("t5_count_m%0d", i + 1), cnt(4), exp_cnt[i]);
      chk($sformatf("t5_sat_m%0d", i + 1), sat(4), exp_sat[i]);
    end
    samp(4, 1, 0, 0, 0); samp(4, 1, 1, 1, 1);
    chk("t5_clr_count", cnt(4), 0);
    chk("t5_clr_sat", sat(4), 0);
    samp(4, 1, 0, 0, 0); samp(4, 1, 1, 0, 1);
    chk("t5_after_clr_count", cnt(4), 1);
    chk("t5_after_clr_sat", sat(4), 0);

    // T6: async reset after "10" discards history
    samp(1, 1, 1, 0, 0); samp(1, 1, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    samp(1, 1, 1, 0, 0); samp(1, 1, 0, 0, 0); samp(1, 1, 1, 0, 1);
    chk("t6_count", cnt(1), 1);

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 5; d++) chk($sformatf("pending_hits_d%0d", d), q[d].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
